// File: rtl/dist_xform_param.sv
// Two-pass (forward/backward raster) distance transform over a packed 1-bit object map.
// Chessboard or city-block metric, saturating distances, out-of-image pixels are background.
module dist_xform_param #(
  parameter int IMG_W  = 128,
  parameter int IMG_H  = 128,
  parameter int STI_W  = 16,
  parameter int DIST_W = 8,
  parameter int STI_AW = 10,
  parameter int RES_AW = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              metric,
  output logic              busy,
  output logic              done,
  output logic              sti_rd,
  output logic [STI_AW-1:0] sti_addr,
  input  logic [STI_W-1:0]  sti_di,
  output logic              res_rd,
  output logic              res_wr,
  output logic [RES_AW-1:0] res_addr,
  output logic [DIST_W-1:0] res_do,
  input  logic [DIST_W-1:0] res_di
);

  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int BW = (STI_W > 1) ? $clog2(STI_W) : 1;
  localparam logic [DIST_W-1:0] DMAX = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_FRD, S_FLAT, S_FPIX, S_BRD, S_BCMP, S_DONE
  } state_t;

  state_t state, state_nx;

  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic [BW-1:0]     bc;
  logic [STI_W-1:0]  pix_sr;
  logic [STI_AW-1:0] sti_ptr;
  logic [RES_AW-1:0] res_ptr;
  logic [DIST_W-1:0] last_d;
  logic [DIST_W-1:0] old_v;
  logic              metric_q;
  logic [DIST_W-1:0] lbuf [IMG_W];

  function automatic logic [DIST_W-1:0] dmin(input logic [DIST_W-1:0] a, input logic [DIST_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [DIST_W-1:0] sat_inc(input logic [DIST_W-1:0] a);
    return (a == DMAX) ? DMAX : a + 1'b1;
  endfunction

  logic              x_first, x_last, y_first, y_last;
  logic [XW-1:0]     xn, xm;
  logic [DIST_W-1:0] l_c, l_n, l_m;
  logic [DIST_W-1:0] a_n, a_ne, a_nw, a_w, fmin, fd;
  logic [DIST_W-1:0] b_s, b_se, b_sw, b_e, bmin, bd;

  // old_v holds the line-buffer entry overwritten on the previous pixel: it is the
  // diagonal neighbour (NW in FWD, SE in BWD) that the in-place update has clobbered.
  always_comb begin
    x_first = (x == '0);
    x_last  = (x == XW'(IMG_W - 1));
    y_first = (y == '0);
    y_last  = (y == YW'(IMG_H - 1));
    xn      = x_last  ? x : x + 1'b1;
    xm      = x_first ? x : x - 1'b1;
    l_c     = lbuf[x];
    l_n     = lbuf[xn];
    l_m     = lbuf[xm];

    a_n  = y_first            ? '0 : l_c;
    a_ne = (y_first | x_last) ? '0 : l_n;
    a_nw = (y_first | x_first) ? '0 : old_v;
    a_w  = x_first            ? '0 : last_d;
    fmin = metric_q ? dmin(a_n, a_w) : dmin(dmin(a_nw, a_n), dmin(a_ne, a_w));
    fd   = pix_sr[STI_W-1] ? sat_inc(fmin) : '0;

    b_s  = y_last             ? '0 : l_c;
    b_se = (y_last | x_last)  ? '0 : old_v;
    b_sw = (y_last | x_first) ? '0 : l_m;
    b_e  = x_last             ? '0 : last_d;
    bmin = metric_q ? dmin(b_s, b_e) : dmin(dmin(b_sw, b_s), dmin(b_se, b_e));
    bd   = dmin(res_di, sat_inc(bmin));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    sti_rd   = 1'b0;
    sti_addr = '0;
    res_rd   = 1'b0;
    res_wr   = 1'b0;
    res_addr = '0;
    res_do   = '0;
    case (state)
      S_IDLE: begin
        if (start) state_nx = S_FRD;
      end
      S_FRD: begin
        busy     = 1'b1;
        sti_rd   = 1'b1;
        sti_addr = sti_ptr;
        state_nx = S_FLAT;
      end
      S_FLAT: begin
        busy     = 1'b1;
        state_nx = S_FPIX;
      end
      S_FPIX: begin
        busy     = 1'b1;
        res_wr   = 1'b1;
        res_addr = res_ptr;
        res_do   = fd;
        if (bc == BW'(STI_W - 1)) state_nx = (x_last && y_last) ? S_BRD : S_FRD;
      end
      S_BRD: begin
        busy     = 1'b1;
        res_rd   = 1'b1;
        res_addr = res_ptr;
        state_nx = S_BCMP;
      end
      S_BCMP: begin
        busy = 1'b1;
        if (bd != res_di) begin
          res_wr   = 1'b1;
          res_addr = res_ptr;
          res_do   = bd;
        end
        state_nx = (x_first && y_first) ? S_DONE : S_BRD;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) state_nx = S_FRD;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x        <= '0;
      y        <= '0;
      bc       <= '0;
      pix_sr   <= '0;
      sti_ptr  <= '0;
      res_ptr  <= '0;
      last_d   <= '0;
      old_v    <= '0;
      metric_q <= 1'b0;
      for (int unsigned i = 0; i < IMG_W; i++) lbuf[i] <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            x        <= '0;
            y        <= '0;
            bc       <= '0;
            sti_ptr  <= '0;
            res_ptr  <= '0;
            metric_q <= metric;
          end
        end
        S_FLAT: begin
          pix_sr  <= sti_di;
          bc      <= '0;
          sti_ptr <= sti_ptr + 1'b1;
        end
        S_FPIX: begin
          lbuf[x] <= fd;
          old_v   <= l_c;
          last_d  <= fd;
          pix_sr  <= pix_sr << 1;
          bc      <= bc + 1'b1;
          res_ptr <= res_ptr + 1'b1;
          if (x_last) begin
            if (y_last) begin
              x       <= XW'(IMG_W - 1);
              res_ptr <= RES_AW'(IMG_W * IMG_H - 1);
            end else begin
              x <= '0;
              y <= y + 1'b1;
            end
          end else begin
            x <= x + 1'b1;
          end
        end
        S_BCMP: begin
          lbuf[x] <= bd;
          old_v   <= l_c;
          last_d  <= bd;
          res_ptr <= res_ptr - 1'b1;
          if (x_first) begin
            x <= XW'(IMG_W - 1);
            y <= y - 1'b1;
          end else begin
            x <= x - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dist_xform_param.sv
// Directed bench for dist_xform_param on 32x32 images; brute-force nearest-background
// reference, one instance with 8-bit and one with 4-bit (saturating) distances.
module tb_dist_xform_param;

  localparam int W  = 32;
  localparam int H  = 32;
  localparam int SW = 16;
  localparam int NW = W * H / SW;

  logic clk = 1'b0;
  logic reset;
  logic metric;
  logic start8, start4;

  logic busy8, done8, sti_rd8, res_rd8, res_wr8;
  logic [5:0]  sti_addr8;
  logic [15:0] sti_di8;
  logic [9:0]  res_addr8;
  logic [7:0]  res_do8, res_di8;

  logic busy4, done4, sti_rd4, res_rd4, res_wr4;
  logic [5:0]  sti_addr4;
  logic [15:0] sti_di4;
  logic [9:0]  res_addr4;
  logic [3:0]  res_do4, res_di4;

  logic [15:0] rom  [NW];
  logic [7:0]  ram8 [W*H];
  logic [3:0]  ram4 [W*H];
  bit          img  [H][W];
  int          expv [H][W];

  int checks = 0;
  int errors = 0;
  int wr8 = 0;
  int clash = 0;

  always #5 clk = ~clk;

  dist_xform_param #(.IMG_W(W), .IMG_H(H), .STI_W(SW), .DIST_W(8), .STI_AW(6), .RES_AW(10)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .metric(metric), .busy(busy8), .done(done8),
    .sti_rd(sti_rd8), .sti_addr(sti_addr8), .sti_di(sti_di8), .res_rd(res_rd8), .res_wr(res_wr8),
    .res_addr(res_addr8), .res_do(res_do8), .res_di(res_di8));

  dist_xform_param #(.IMG_W(W), .IMG_H(H), .STI_W(SW), .DIST_W(4), .STI_AW(6), .RES_AW(10)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .metric(metric), .busy(busy4), .done(done4),
    .sti_rd(sti_rd4), .sti_addr(sti_addr4), .sti_di(sti_di4), .res_rd(res_rd4), .res_wr(res_wr4),
    .res_addr(res_addr4), .res_do(res_do4), .res_di(res_di4));

  always @(posedge clk) begin
    if (sti_rd8) sti_di8 <= rom[sti_addr8];
    if (sti_rd4) sti_di4 <= rom[sti_addr4];
    if (res_wr8) ram8[res_addr8] <= res_do8;
    if (res_rd8) res_di8 <= ram8[res_addr8];
    if (res_wr4) ram4[res_addr4] <= res_do4;
    if (res_rd4) res_di4 <= ram4[res_addr4];
    if (res_wr8) wr8 <= wr8 + 1;
    if ((res_rd8 && res_wr8) || (res_rd4 && res_wr4)) clash <= clash + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    checks++;
    assert (obs === expd) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expd);
    end
  endtask

  task automatic load_rom();
    for (int y = 0; y < H; y++)
      for (int wd = 0; wd < W / SW; wd++)
        for (int k = 0; k < SW; k++)
          rom[y * (W / SW) + wd][SW - 1 - k] = img[y][wd * SW + k];
  endtask

  task automatic fill_img(input int kind);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        case (kind)
          0: img[y][x] = 1'b0;
          1: img[y][x] = (x == 5 && y == 5);
          2: img[y][x] = (x >= 10 && x <= 12 && y >= 10 && y <= 12 && !(x == 12 && y == 12));
          3: img[y][x] = 1'b1;
          default: img[y][x] = ($urandom_range(0, 9) < 8);
        endcase
    load_rom();
  endtask

  // Nearest background pixel by exhaustive search; the image border counts as background.
  task automatic compute_ref(input int met, input int maxv);
    int best, dx, dy, dd;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        if (!img[y][x]) begin
          expv[y][x] = 0;
        end else begin
          best = x + 1;
          if (y + 1 < best) best = y + 1;
          if (W - x < best) best = W - x;
          if (H - y < best) best = H - y;
          for (int qy = 0; qy < H; qy++)
            for (int qx = 0; qx < W; qx++)
              if (!img[qy][qx]) begin
                dx = (qx > x) ? qx - x : x - qx;
                dy = (qy > y) ? qy - y : y - qy;
                dd = met ? dx + dy : ((dx > dy) ? dx : dy);
                if (dd < best) best = dd;
              end
          expv[y][x] = (best > maxv) ? maxv : best;
        end
      end
  endtask

  task automatic check_img(input string tag, input int use4);
    int bad = 0;
    logic [31:0] v;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        v = use4 ? {28'b0, ram4[y * W + x]} : {24'b0, ram8[y * W + x]};
        if (v !== expv[y][x]) bad++;
      end
    check({tag, "_bad_pixels"}, bad, 0);
  endtask

  task automatic set_start(input int use4, input logic v);
    if (use4 != 0) start4 = v;
    else           start8 = v;
  endtask

  task automatic run(input int use4, input logic met, input int poke, input string tag);
    int n = 0;
    @(negedge clk);
    metric = met;
    set_start(use4, 1'b1);
    @(negedge clk);
    set_start(use4, 1'b0);
    metric = ~met;
    check({tag, "_busy_after_start"}, {30'b0, (use4 != 0) ? {busy4, done4} : {busy8, done8}}, 32'd2);
    while (((use4 != 0) ? done4 : done8) !== 1'b1 && n < 10000) begin
      @(negedge clk);
      n++;
      if (poke != 0 && n == 60) set_start(use4, 1'b1);
      if (poke != 0 && n == 61) set_start(use4, 1'b0);
    end
    check({tag, "_done"}, {31'b0, (use4 != 0) ? done4 : done8}, 1);
  endtask

  initial begin
    int base;
    reset  = 1'b0;
    start8 = 1'b0;
    start4 = 1'b0;
    metric = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs8", {3'b0, busy8, done8, sti_rd8, res_rd8, res_wr8, sti_addr8, res_addr8, res_do8}, 0);
    check("reset_outputs4", {7'b0, busy4, done4, sti_rd4, res_rd4, res_wr4, sti_addr4, res_addr4, res_do4}, 0);
    reset = 1'b1;

    fill_img(0);
    compute_ref(0, 255);
    base = wr8;
    run(0, 1'b0, 0, "zero_chess");
    check("zero_chess_writes", wr8 - base, W * H);
    check_img("zero_chess", 0);
    repeat (5) @(negedge clk);
    check("done_held", {30'b0, busy8, done8}, 1);

    base = wr8;
    run(0, 1'b1, 0, "zero_city");
    check("zero_city_writes", wr8 - base, W * H);
    check_img("zero_city", 0);

    fill_img(1);
    compute_ref(0, 255);
    base = wr8;
    run(0, 1'b0, 0, "single");
    check("single_5_5", {24'b0, ram8[5 * W + 5]}, 1);
    check("single_writes", wr8 - base, W * H);
    check_img("single", 0);

    fill_img(2);
    compute_ref(0, 255);
    run(0, 1'b0, 0, "blk_chess");
    check("blk_chess_centre", {24'b0, ram8[11 * W + 11]}, 1);
    check_img("blk_chess", 0);
    compute_ref(1, 255);
    run(0, 1'b1, 0, "blk_city");
    check("blk_city_centre", {24'b0, ram8[11 * W + 11]}, 2);
    check("blk_city_10_10", {24'b0, ram8[10 * W + 10]}, 1);
    check_img("blk_city", 0);

    fill_img(3);
    compute_ref(0, 255);
    run(0, 1'b0, 0, "ones8");
    check("ones8_centre", {24'b0, ram8[15 * W + 15]}, 16);
    check("ones8_corner", {24'b0, ram8[31 * W + 31]}, 1);
    check("ones8_3_14", {24'b0, ram8[3 * W + 14]}, 4);
    check_img("ones8", 0);

    compute_ref(0, 15);
    run(1, 1'b0, 0, "ones4");
    check("ones4_centre_sat", {28'b0, ram4[15 * W + 15]}, 15);
    check("ones4_3_14", {28'b0, ram4[3 * W + 14]}, 4);
    check_img("ones4", 1);

    fill_img(4);
    compute_ref(1, 255);
    @(negedge clk);
    metric = 1'b1;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (40) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("midrun_reset_outputs", {3'b0, busy8, done8, sti_rd8, res_rd8, res_wr8, sti_addr8, res_addr8, res_do8}, 0);
    @(negedge clk);
    reset = 1'b1;
    run(0, 1'b1, 1, "restart_city");
    check_img("restart_city", 0);

    check("strobe_clash", clash, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
